// File: rtl/hilo_unit.sv
// hilo_unit -- HI/LO register owner for the pipeline CPU.
//
// Sequences one multiply. It takes the start pulse and counts the
// multiplier's iterations. It then commits the 64-bit product to HI/LO:
// MULTU overwrites the registers and MADDU accumulates into them. It also
// serves MFHI/MFLO reads and holds the pipeline while a multiply is in
// flight.
//
// Optional feature: define HILO_ACC_OVF_EN to get a sticky MADDU carry-out
// flag on acc_ovf. Without it, acc_ovf is tied low and no carry logic is built.
//
// Ports:
//   clk      in   1   clock, rising edge
//   reset    in   1   asynchronous, active-high reset
//   Signal   in   4   op code (MULTU/MADDU/MFHI/MFLO/OUT, others no-op)
//   start    in   1   first cycle of a MULTU/MADDU
//   product  in  64   multiplier output, sampled at the commit edge
//   hi, lo   out 32   architectural HI/LO registers
//   dataOut  out 32   MFHI/MFLO read data (0 otherwise)
//   busy     out  1   multiply in flight
//   stall    out  1   pipeline hold request
//   done     out  1   one-cycle pulse after a commit
//   acc_ovf  out  1   sticky MADDU carry-out
module hilo_unit #(
    parameter int CYCLES = 32,
    parameter int CNT_W  = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  Signal,
    input  logic        start,
    input  logic [63:0] product,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] dataOut,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic        acc_ovf
);
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_MADDU = 4'b1011;
    localparam logic [3:0] OP_MFHI  = 4'b1100;
    localparam logic [3:0] OP_MFLO  = 4'b1101;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              madd_q, madd_d;
    logic [63:0]       hilo_q, hilo_d;
    logic              done_q, done_d;
    logic              commit;
    logic              op_match;
    logic              is_mf;
    logic [63:0]       acc_sum;

`ifdef HILO_ACC_OVF_EN
    logic [64:0] sum65;
    logic        ovf_q;
    assign sum65   = {1'b0, hilo_q} + {1'b0, product};
    assign acc_sum = sum65[63:0];
`else
    assign acc_sum = hilo_q + product;
`endif

    // The op in flight must stay on Signal for every iteration; any other
    // code means the pipeline moved on and the multiply is abandoned.
    assign op_match = (Signal == (madd_q ? OP_MADDU : OP_MULTU));
    assign is_mf    = (Signal == OP_MFHI) || (Signal == OP_MFLO);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        madd_d  = madd_q;
        hilo_d  = hilo_q;
        done_d  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && (Signal == OP_MULTU || Signal == OP_MADDU)) begin
                    state_d = RUN;
                    madd_d  = (Signal == OP_MADDU);
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            RUN: begin
                if (!op_match) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    hilo_d  = madd_q ? acc_sum : product;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            madd_q  <= 1'b0;
            hilo_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            madd_q  <= madd_d;
            hilo_q  <= hilo_d;
            done_q  <= done_d;
        end
    end

`ifdef HILO_ACC_OVF_EN
    // Sticky: set by a carrying MADDU, cleared only by a MULTU commit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ovf_q <= 1'b0;
        else if (commit)
            ovf_q <= madd_q ? (ovf_q | sum65[64]) : 1'b0;
    end
    assign acc_ovf = ovf_q;
`else
    assign acc_ovf = 1'b0;
`endif

    assign hi      = hilo_q[63:32];
    assign lo      = hilo_q[31:0];
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    // Reads see the registers as they stand; there is no product bypass.
    assign dataOut = (Signal == OP_MFHI) ? hilo_q[63:32] :
                     (Signal == OP_MFLO) ? hilo_q[31:0]  : 32'd0;
    assign stall   = busy & (is_mf | start | op_match);
endmodule

// File: tb/tb_hilo_unit.sv
module tb_hilo_unit;
    localparam int CYC = 32;
    localparam logic [3:0] MULTU = 4'b1010, MADDU = 4'b1011,
                           MFHI = 4'b1100, MFLO = 4'b1101, OUTC = 4'b1111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  Signal = OUTC;
    logic        start = 1'b0;
    logic [63:0] product = '0;
    logic [31:0] hi, lo, dataOut;
    logic        busy, stall, done, acc_ovf;

    hilo_unit #(.CYCLES(CYC), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .Signal(Signal), .start(start),
        .product(product), .hi(hi), .lo(lo), .dataOut(dataOut),
        .busy(busy), .stall(stall), .done(done), .acc_ovf(acc_ovf)
    );

    always #5 clk = ~clk;

`ifdef HILO_ACC_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    // Behavioural model: a multiply is "in flight" with a number of
    // remaining matching edges; the last one commits.
    bit          m_busy = 0, m_madd = 0, m_done = 0, m_ovf = 0;
    int          m_rem = 0;
    logic [63:0] m_hilo = '0;
    logic [64:0] m_sum;
    assign m_sum = {1'b0, m_hilo} + {1'b0, product};

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy <= 0; m_madd <= 0; m_done <= 0; m_ovf <= 0;
            m_rem <= 0; m_hilo <= '0;
        end else begin
            m_done <= 0;
            if (!m_busy) begin
                if (start && (Signal == MULTU || Signal == MADDU)) begin
                    m_busy <= 1;
                    m_madd <= (Signal == MADDU);
                    m_rem  <= CYC;
                end
            end else if (Signal != (m_madd ? MADDU : MULTU)) begin
                m_busy <= 0;
            end else if (m_rem == 1) begin
                m_busy <= 0;
                m_done <= 1;
                if (m_madd) begin
                    m_hilo <= m_sum[63:0];
                    if (OVF_ON && m_sum[64]) m_ovf <= 1;
                end else begin
                    m_hilo <= product;
                    m_ovf  <= 0;
                end
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    // Hand-computed literal expectations, checked at the next negedge.
    int          lit_seq = 0;
    logic [31:0] l_hi, l_lo, l_dout;
    logic        l_busy, l_stall, l_ovf;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    initial begin : compare
        int seen;
        logic [31:0] e_dout;
        logic        e_stall;
        seen = 0;
        forever begin
            @(negedge clk);
            e_dout  = (Signal == MFHI) ? m_hilo[63:32] :
                      (Signal == MFLO) ? m_hilo[31:0] : 32'd0;
            e_stall = m_busy && (Signal == MFHI || Signal == MFLO || start ||
                                 Signal == (m_madd ? MADDU : MULTU));
            chk("hi", hi, m_hilo[63:32]);
            chk("lo", lo, m_hilo[31:0]);
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("stall", stall, e_stall);
            chk("dataOut", dataOut, e_dout);
            chk("acc_ovf", acc_ovf, m_ovf);
            if (seen != lit_seq) begin
                seen = lit_seq;
                chk("lit_hi", hi, l_hi);
                chk("lit_lo", lo, l_lo);
                chk("lit_busy", busy, l_busy);
                chk("lit_stall", stall, l_stall);
                chk("lit_dataOut", dataOut, l_dout);
                chk("lit_acc_ovf", acc_ovf, l_ovf);
            end
        end
    end

    // Apply inputs for one cycle; returns just after the sampling edge.
    task automatic drv(input logic [3:0] s, input logic st, input logic [63:0] p);
        Signal = s; start = st; product = p;
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [3:0] op, input logic [63:0] p, input int n);
        drv(op, 1'b1, p);
        repeat (n) drv(op, 1'b0, p);
    endtask

    // Literal describing the cycle driven by the next drv call.
    task automatic lit(input logic [31:0] h, input logic [31:0] l, input logic b,
                       input logic s, input logic [31:0] d, input logic o);
        l_hi = h; l_lo = l; l_busy = b; l_stall = s; l_dout = d; l_ovf = o;
        lit_seq++;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        lit(0, 0, 0, 0, 0, 0);
        drv(OUTC, 0, 0);

        // MULTU 15
        run(MULTU, 64'd15, CYC);
        lit(0, 15, 0, 0, 15, 0);
        drv(MFLO, 0, 0);

        // MADDU carry from lo into hi
        run(MULTU, 64'h0000_0000_FFFF_FFFF, CYC);
        run(MADDU, 64'd1, CYC);
        lit(1, 0, 0, 0, 1, 0);
        drv(MFHI, 0, 0);

        // Read hazard while in flight (the read also aborts the multiply)
        run(MULTU, {32'd7, 32'd0}, CYC);
        run(MULTU, 64'hDEAD, 3);
        lit(7, 0, 1, 1, 7, 0);
        drv(MFHI, 0, 0);
        lit(7, 0, 0, 0, 7, 0);
        drv(MFHI, 0, 0);

        // Reset at cnt=10, then a clean MULTU
        run(MULTU, 64'd99, 9);
        reset = 1'b1;
        lit(0, 0, 0, 0, 0, 0);
        drv(OUTC, 0, 0);
        reset = 1'b0;
        drv(OUTC, 0, 0);
        run(MULTU, 64'd5, CYC);
        lit(0, 5, 0, 0, 5, 0);
        drv(MFLO, 0, 0);

        // Abort at cnt=5
        run(MULTU, 64'd77, 4);
        lit(0, 5, 1, 1, 5, 0);
        drv(MFLO, 0, 0);
        lit(0, 5, 0, 0, 0, 0);
        drv(OUTC, 0, 0);

        // start during RUN must not restart the count
        run(MULTU, 64'h1_0000_0002, 3);
        lit(0, 5, 1, 1, 0, 0);
        drv(MULTU, 1, 64'h1_0000_0002);
        repeat (CYC - 4) drv(MULTU, 0, 64'h1_0000_0002);
        lit(1, 2, 0, 0, 0, 0);
        drv(OUTC, 0, 0);

        // MADDU wrap with carry-out, then MULTU clears the flag
        run(MULTU, 64'hFFFF_FFFF_FFFF_FFFF, CYC);
        lit(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        drv(OUTC, 0, 0);
        run(MADDU, 64'd2, CYC);
        lit(0, 1, 0, 0, 0, OVF_ON);
        drv(OUTC, 0, 0);
        run(MULTU, 64'd3, CYC);
        lit(0, 3, 0, 0, 3, 0);
        drv(MFLO, 0, 0);
        drv(OUTC, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
